// File: rtl/interrupt_controller_pkg.sv
// -----------------------------------------------------------------------------
// interrupt_controller_pkg
// Shared definitions for the interrupt controller: dispatch vectors, register
// addresses, FSM state encodings and the index-to-vector helper.
// -----------------------------------------------------------------------------
package interrupt_controller_pkg;

    // Number of interrupt sources (VBlank, LCD STAT, timer, serial, joypad).
    localparam int NUM_SOURCES = 5;

    // Dispatch vectors, one per source, in priority order.
    localparam logic [7:0] VECTOR_VBLANK = 8'h40;
    localparam logic [7:0] VECTOR_STAT   = 8'h48;
    localparam logic [7:0] VECTOR_TIMER  = 8'h50;
    localparam logic [7:0] VECTOR_SERIAL = 8'h58;
    localparam logic [7:0] VECTOR_JOYPAD = 8'h60;

    // Memory-mapped register addresses decoded by the CPU into write strobes.
    localparam logic [15:0] ADDR_IF = 16'hFF0F;
    localparam logic [15:0] ADDR_IE = 16'hFFFF;

    // Unimplemented IF bits always read back as ones.
    localparam logic [2:0] IF_UNUSED_BITS = 3'b111;

    // Dispatch FSM.
    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_DISPATCH = 1'b1
    } state_t;

    // Delayed-EI tracking: EI takes effect after its own instruction
    // boundary and then the boundary of the following instruction.
    typedef enum logic [1:0] {
        EI_NONE      = 2'd0,
        EI_WAIT_OWN  = 2'd1,
        EI_WAIT_NEXT = 2'd2
    } ei_stage_t;

    // Vector for a source index: 0x40 + 8*index.
    function automatic logic [7:0] vector_for_index(input logic [2:0] index);
        return VECTOR_VBLANK + {2'b00, index, 3'b000};
    endfunction

endpackage

// File: rtl/FFD_POSEDGE_SYNCRONOUS_RESET.sv
// -----------------------------------------------------------------------------
// FFD_POSEDGE_SYNCRONOUS_RESET
// Shared register primitive: rising-edge flop bank with synchronous,
// active-high reset to zero and a load enable.
// Ports:
//   Clock  - rising-edge clock
//   Reset  - synchronous active-high reset (Q <= 0)
//   Enable - load enable
//   D      - next value
//   Q      - registered value
// -----------------------------------------------------------------------------
module FFD_POSEDGE_SYNCRONOUS_RESET #(
    parameter int SIZE = 1
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Enable,
    input  logic [SIZE-1:0] D,
    output logic [SIZE-1:0] Q
);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Q <= '0;
        end else if (Enable) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/interrupt_priority_encoder.sv
// -----------------------------------------------------------------------------
// interrupt_priority_encoder
// Purely combinational: picks the lowest set bit of the pending vector
// (bit 0 = highest priority).
// Ports:
//   iPending - enabled-and-flagged sources
//   oIndex   - index of the winning source (0 when none)
//   oValid   - at least one source pending
// -----------------------------------------------------------------------------
module interrupt_priority_encoder
    import interrupt_controller_pkg::*;
(
    input  logic [NUM_SOURCES-1:0] iPending,
    output logic [2:0]             oIndex,
    output logic                   oValid
);

    always_comb begin
        oIndex = 3'd0;
        oValid = 1'b0;
        // Scan from the lowest priority upward so the last hit is bit 0 side.
        for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
            if (iPending[k]) begin
                oIndex = 3'(k);
                oValid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
// Holds IF/IE/IME, tracks delayed EI, and decides interrupt dispatch at CPU
// instruction boundaries.
// Ports:
//   iClock, iReset               - clock, synchronous active-high reset
//   iInt0x40..iInt0x60           - one-cycle request pulses per source
//   iEof                         - end-of-instruction strobe (dispatch point)
//   iEi, iDi, iReti              - instruction decode pulses
//   iMcuWeIf, iMcuWeIe           - CPU write strobes for IF / IE
//   iMcuWriteData                - CPU write data
//   iDispatchAck                 - CPU has taken the dispatch
//   oIf, oIe, oIme               - register readback
//   oIrqReq, oIrqVector          - dispatch request and its vector
//   oHaltWake                    - any enabled flag set (ignores IME)
//
// Handshake: oIrqReq rises with oIrqVector valid at an instruction boundary
// and is held, with index and vector frozen, until iDispatchAck is seen;
// the acknowledged flag is cleared in that same cycle. iDispatchAck is
// ignored when no request is outstanding.
// -----------------------------------------------------------------------------
module interrupt_controller
    import interrupt_controller_pkg::*;
(
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iInt0x40,
    input  logic       iInt0x48,
    input  logic       iInt0x50,
    input  logic       iInt0x58,
    input  logic       iInt0x60,
    input  logic       iEof,
    input  logic       iEi,
    input  logic       iDi,
    input  logic       iReti,
    input  logic       iMcuWeIf,
    input  logic       iMcuWeIe,
    input  logic [7:0] iMcuWriteData,
    input  logic       iDispatchAck,
    output logic [7:0] oIf,
    output logic [7:0] oIe,
    output logic       oIme,
    output logic       oIrqReq,
    output logic [7:0] oIrqVector,
    output logic       oHaltWake
);

    logic [NUM_SOURCES-1:0] flags_d, flags_q;
    logic [7:0]             ie_d, ie_q;
    logic                   ime_d, ime_q;
    logic [1:0]             ei_stage_d, ei_stage_q;
    logic [0:0]             state_d, state_q_raw;
    logic [2:0]             index_d, index_q;
    logic                   irq_req_d, irq_req_q;
    logic [7:0]             vector_d, vector_q;

    state_t                 state_q;
    ei_stage_t              ei_stage;
    logic [NUM_SOURCES-1:0] requests;
    logic [NUM_SOURCES-1:0] pending;
    logic [2:0]             enc_index;
    logic                   enc_valid;

    assign requests = {iInt0x60, iInt0x58, iInt0x50, iInt0x48, iInt0x40};
    assign pending  = flags_q & ie_q[NUM_SOURCES-1:0];
    assign state_q  = state_t'(state_q_raw);
    assign ei_stage = ei_stage_t'(ei_stage_q);

    interrupt_priority_encoder u_priority_encoder (
        .iPending (pending),
        .oIndex   (enc_index),
        .oValid   (enc_valid)
    );

    always_comb begin
        flags_d    = flags_q;
        ie_d       = ie_q;
        ime_d      = ime_q;
        ei_stage_d = ei_stage_q;
        state_d    = state_q_raw;
        index_d    = index_q;
        irq_req_d  = irq_req_q;
        vector_d   = vector_q;

        // Flags: CPU write, then ack clear, then new requests (set wins).
        if (iMcuWeIf) begin
            flags_d = iMcuWriteData[NUM_SOURCES-1:0];
        end
        if (state_q == ST_DISPATCH && iDispatchAck) begin
            for (int k = 0; k < NUM_SOURCES; k++) begin
                if (index_q == 3'(k)) begin
                    flags_d[k] = 1'b0;
                end
            end
        end
        flags_d = flags_d | requests;

        if (iMcuWeIe) begin
            ie_d = iMcuWriteData;
        end

        // IME control. Later assignments take precedence: RETI, then the
        // delayed EI, then DI (DI beats EI in the same cycle).
        if (iReti) begin
            ime_d      = 1'b1;
            ei_stage_d = EI_NONE;
        end

        if (iEi) begin
            // An EI whose own boundary arrives in the same cycle has
            // already passed its first boundary.
            ei_stage_d = iEof ? EI_WAIT_NEXT : EI_WAIT_OWN;
        end else if (iEof) begin
            case (ei_stage)
                EI_WAIT_OWN:  ei_stage_d = EI_WAIT_NEXT;
                EI_WAIT_NEXT: begin
                    ei_stage_d = EI_NONE;
                    ime_d      = 1'b1;
                end
                default:      ei_stage_d = ei_stage_q;
            endcase
        end

        if (iDi) begin
            ime_d      = 1'b0;
            ei_stage_d = EI_NONE;
        end

        // Dispatch FSM. Uses the current IME, so an EI completing at this
        // boundary only allows dispatch at a later boundary.
        case (state_q)
            ST_IDLE: begin
                if (iEof && ime_q && !iDi && enc_valid) begin
                    state_d   = ST_DISPATCH;
                    index_d   = enc_index;
                    vector_d  = vector_for_index(enc_index);
                    irq_req_d = 1'b1;
                    ime_d     = 1'b0;
                end
            end
            ST_DISPATCH: begin
                if (iDispatchAck) begin
                    state_d   = ST_IDLE;
                    irq_req_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    FFD_POSEDGE_SYNCRONOUS_RESET #(.SIZE(NUM_SOURCES)) u_flags_ff (
        .Clock(iClock), .Reset(iReset), .Enable(1'b1), .D(flags_d), .Q(flags_q)
    );
    FFD_POSEDGE_SYNCRONOUS_RESET #(.SIZE(8)) u_ie_ff (
        .Clock(iClock), .Reset(iReset), .Enable(1'b1), .D(ie_d), .Q(ie_q)
    );
    FFD_POSEDGE_SYNCRONOUS_RESET #(.SIZE(1)) u_ime_ff (
        .Clock(iClock), .Reset(iReset), .Enable(1'b1), .D(ime_d), .Q(ime_q)
    );
    FFD_POSEDGE_SYNCRONOUS_RESET #(.SIZE(2)) u_ei_stage_ff (
        .Clock(iClock), .Reset(iReset), .Enable(1'b1), .D(ei_stage_d), .Q(ei_stage_q)
    );
    FFD_POSEDGE_SYNCRONOUS_RESET #(.SIZE(1)) u_state_ff (
        .Clock(iClock), .Reset(iReset), .Enable(1'b1), .D(state_d), .Q(state_q_raw)
    );
    FFD_POSEDGE_SYNCRONOUS_RESET #(.SIZE(3)) u_index_ff (
        .Clock(iClock), .Reset(iReset), .Enable(1'b1), .D(index_d), .Q(index_q)
    );
    FFD_POSEDGE_SYNCRONOUS_RESET #(.SIZE(1)) u_irq_req_ff (
        .Clock(iClock), .Reset(iReset), .Enable(1'b1), .D(irq_req_d), .Q(irq_req_q)
    );
    FFD_POSEDGE_SYNCRONOUS_RESET #(.SIZE(8)) u_vector_ff (
        .Clock(iClock), .Reset(iReset), .Enable(1'b1), .D(vector_d), .Q(vector_q)
    );

    assign oIf        = {IF_UNUSED_BITS, flags_q};
    assign oIe        = ie_q;
    assign oIme       = ime_q;
    assign oIrqReq    = irq_req_q;
    assign oIrqVector = vector_q;
    assign oHaltWake  = |pending;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

    typedef struct {
        logic       rst;
        logic [4:0] ints;
        logic       eof;
        logic       ei;
        logic       di;
        logic       reti;
        logic       we_if;
        logic       we_ie;
        logic [7:0] wdata;
        logic       ack;
        logic [7:0] e_if;
        logic [7:0] e_ie;
        logic       e_ime;
        logic       e_irq;
        logic [7:0] e_vec;
        logic       e_wake;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ints;
    logic       eof, ei, di, reti, we_if, we_ie, ack;
    logic [7:0] wdata;
    logic [7:0] o_if, o_ie, o_vec;
    logic       o_ime, o_irq, o_wake;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    interrupt_controller dut (
        .iClock        (clk),
        .iReset        (rst),
        .iInt0x40      (ints[0]),
        .iInt0x48      (ints[1]),
        .iInt0x50      (ints[2]),
        .iInt0x58      (ints[3]),
        .iInt0x60      (ints[4]),
        .iEof          (eof),
        .iEi           (ei),
        .iDi           (di),
        .iReti         (reti),
        .iMcuWeIf      (we_if),
        .iMcuWeIe      (we_ie),
        .iMcuWriteData (wdata),
        .iDispatchAck  (ack),
        .oIf           (o_if),
        .oIe           (o_ie),
        .oIme          (o_ime),
        .oIrqReq       (o_irq),
        .oIrqVector    (o_vec),
        .oHaltWake     (o_wake)
    );

    // ---------------- driver / checker ----------------
    function automatic vec_t mk(input logic r, input logic [4:0] i, input logic e,
                                input logic en, input logic d, input logic rt,
                                input logic wif, input logic wie, input logic [7:0] wd,
                                input logic a, input logic [7:0] xif, input logic [7:0] xie,
                                input logic xime, input logic xirq, input logic [7:0] xvec,
                                input logic xwake);
        vec_t v;
        v.rst = r; v.ints = i; v.eof = e; v.ei = en; v.di = d; v.reti = rt;
        v.we_if = wif; v.we_ie = wie; v.wdata = wd; v.ack = a;
        v.e_if = xif; v.e_ie = xie; v.e_ime = xime; v.e_irq = xirq;
        v.e_vec = xvec; v.e_wake = xwake;
        return v;
    endfunction

    // Drive one cycle of inputs at the falling edge; outputs are sampled at
    // the next falling edge, after the rising edge that consumed them.
    task automatic step(input vec_t v);
        rst = v.rst; ints = v.ints; eof = v.eof; ei = v.ei; di = v.di;
        reti = v.reti; we_if = v.we_if; we_ie = v.we_ie; wdata = v.wdata; ack = v.ack;
        @(negedge clk);
        rst = 1'b0; ints = '0; eof = 1'b0; ei = 1'b0; di = 1'b0;
        reti = 1'b0; we_if = 1'b0; we_ie = 1'b0; wdata = '0; ack = 1'b0;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " oIf"},        o_if,          v.e_if);
        check({tag, " oIe"},        o_ie,          v.e_ie);
        check({tag, " oIme"},       {7'd0, o_ime},  {7'd0, v.e_ime});
        check({tag, " oIrqReq"},    {7'd0, o_irq},  {7'd0, v.e_irq});
        check({tag, " oIrqVector"}, o_vec,         v.e_vec);
        check({tag, " oHaltWake"},  {7'd0, o_wake}, {7'd0, v.e_wake});
    endtask

    // Input-only helper for hand-written sequences (expectations unused).
    function automatic vec_t in_only(input logic r, input logic [4:0] i, input logic e,
                                     input logic en, input logic d, input logic rt,
                                     input logic wif, input logic wie, input logic [7:0] wd,
                                     input logic a);
        return mk(r, i, e, en, d, rt, wif, wie, wd, a, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    endfunction

    vec_t tbl[$];

    initial begin
        rst = 1'b1; ints = '0; eof = 1'b0; ei = 1'b0; di = 1'b0; reti = 1'b0;
        we_if = 1'b0; we_ie = 1'b0; wdata = '0; ack = 1'b0;
        @(negedge clk);

        //            rst  ints   eof ei di rt wif wie wdata  ack | IF     IE     ime irq vec    wake
        // Reset with coincident requests: requests discarded.
        tbl.push_back(mk(1, 5'h1F, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'hE0, 8'h00, 0, 0, 8'h00, 0));
        // Timer dispatch and acknowledge.
        tbl.push_back(mk(0, 5'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 8'hE0, 8'h00, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 1, 8'h04, 0, 8'hE0, 8'h04, 1, 0, 8'h00, 0));
        tbl.push_back(mk(0, 5'h04, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'hE4, 8'h04, 1, 0, 8'h00, 1));
        tbl.push_back(mk(0, 5'h00, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'hE4, 8'h04, 0, 1, 8'h50, 1));
        tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'hE4, 8'h04, 0, 1, 8'h50, 1));
        tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'hE0, 8'h04, 0, 0, 8'h50, 0));
        // Ack while idle is ignored.
        tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'hE0, 8'h04, 0, 0, 8'h50, 0));
        // Priority: flags 0x12, IE 0x1F -> STAT (0x48) wins.
        tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 1, 8'h1F, 0, 8'hE0, 8'h1F, 0, 0, 8'h50, 0));
        tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 1, 0, 8'h12, 0, 8'hF2, 8'h1F, 0, 0, 8'h50, 1));
        tbl.push_back(mk(0, 5'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 8'hF2, 8'h1F, 1, 0, 8'h50, 1));
        tbl.push_back(mk(0, 5'h00, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'hF2, 8'h1F, 0, 1, 8'h48, 1));
        tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'hF0, 8'h1F, 0, 0, 8'h48, 1));
        // IME=0: boundary does not dispatch, flag persists.
        tbl.push_back(mk(0, 5'h00, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'hF0, 8'h1F, 0, 0, 8'h48, 1));
        // IF write 0x00 with joypad request: set wins.
        tbl.push_back(mk(0, 5'h10, 0, 0, 0, 0, 1, 0, 8'h00, 0, 8'hF0, 8'h1F, 0, 0, 8'h48, 1));
        tbl.push_back(mk(0, 5'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 8'hF0, 8'h1F, 1, 0, 8'h48, 1));
        tbl.push_back(mk(0, 5'h00, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'hF0, 8'h1F, 0, 1, 8'h60, 1));
        // IF write honoured in DISPATCH, vector frozen.
        tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 1, 0, 8'h01, 0, 8'hE1, 8'h1F, 0, 1, 8'h60, 1));
        // Ack with a new request for the same bit: request wins.
        tbl.push_back(mk(0, 5'h10, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'hF1, 8'h1F, 0, 0, 8'h60, 1));
        tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 1, 0, 8'h00, 0, 8'hE0, 8'h1F, 0, 0, 8'h60, 0));
        // DI coincident with EOF blocks dispatch.
        tbl.push_back(mk(0, 5'h01, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'hE1, 8'h1F, 0, 0, 8'h60, 1));
        tbl.push_back(mk(0, 5'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 8'hE1, 8'h1F, 1, 0, 8'h60, 1));
        tbl.push_back(mk(0, 5'h00, 1, 0, 1, 0, 0, 0, 8'h00, 0, 8'hE1, 8'h1F, 0, 0, 8'h60, 1));
        tbl.push_back(mk(0, 5'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 8'hE1, 8'h1F, 1, 0, 8'h60, 1));
        tbl.push_back(mk(0, 5'h00, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'hE1, 8'h1F, 0, 1, 8'h40, 1));
        tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'hE0, 8'h1F, 0, 0, 8'h40, 0));
        // EI and DI together: DI wins, IME stays 0 over later boundaries.
        tbl.push_back(mk(0, 5'h00, 0, 1, 1, 0, 0, 0, 8'h00, 0, 8'hE0, 8'h1F, 0, 0, 8'h40, 0));
        tbl.push_back(mk(0, 5'h00, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'hE0, 8'h1F, 0, 0, 8'h40, 0));
        tbl.push_back(mk(0, 5'h00, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'hE0, 8'h1F, 0, 0, 8'h40, 0));
        // IE stores all 8 bits.
        tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 1, 8'hA5, 0, 8'hE0, 8'hA5, 0, 0, 8'h40, 0));
        tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 0, 1, 8'h00, 0, 8'hE0, 8'h00, 0, 0, 8'h40, 0));
        // IME=1 but IE bit clear: flag persists, no dispatch, no wake.
        tbl.push_back(mk(0, 5'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 8'hE0, 8'h00, 1, 0, 8'h40, 0));
        tbl.push_back(mk(0, 5'h08, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'hE8, 8'h00, 1, 0, 8'h40, 0));
        tbl.push_back(mk(0, 5'h00, 1, 0, 0, 0, 0, 0, 8'h00, 0, 8'hE8, 8'h00, 1, 0, 8'h40, 0));
        tbl.push_back(mk(0, 5'h00, 0, 0, 0, 0, 1, 0, 8'h00, 0, 8'hE0, 8'h00, 1, 0, 8'h40, 0));
        tbl.push_back(mk(0, 5'h00, 0, 0, 1, 0, 0, 0, 8'h00, 0, 8'hE0, 8'h00, 0, 0, 8'h40, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
            check_all($sformatf("vec%0d", i), tbl[i]);
        end

        // ---- Delayed EI: IE=0x01, flag0 set ----
        step(in_only(0, 5'h00, 0, 0, 0, 0, 0, 1, 8'h01, 0));
        step(in_only(0, 5'h01, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        step(in_only(0, 5'h00, 0, 1, 0, 0, 0, 0, 8'h00, 0));
        check("ei pulse oIme", {7'd0, o_ime}, 8'h00);
        step(in_only(0, 5'h00, 1, 0, 0, 0, 0, 0, 8'h00, 0));
        check("ei eof1 oIme", {7'd0, o_ime}, 8'h00);
        check("ei eof1 oIrqReq", {7'd0, o_irq}, 8'h00);
        step(in_only(0, 5'h00, 1, 0, 0, 0, 0, 0, 8'h00, 0));
        check("ei eof2 oIme", {7'd0, o_ime}, 8'h01);
        check("ei eof2 oIrqReq", {7'd0, o_irq}, 8'h00);
        step(in_only(0, 5'h00, 1, 0, 0, 0, 0, 0, 8'h00, 0));
        check("ei eof3 oIrqReq", {7'd0, o_irq}, 8'h01);
        check("ei eof3 oIrqVector", o_vec, 8'h40);
        check("ei eof3 oIme", {7'd0, o_ime}, 8'h00);
        step(in_only(0, 5'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1));
        check("ei ack oIf", o_if, 8'hE0);
        check("ei ack oIrqReq", {7'd0, o_irq}, 8'h00);

        // ---- IF write 0x00 + joypad request, IME=0, IE=0x10 ----
        step(in_only(0, 5'h00, 0, 0, 0, 0, 0, 1, 8'h10, 0));
        step(in_only(0, 5'h10, 0, 0, 0, 0, 1, 0, 8'h00, 0));
        check("wake oIf", o_if, 8'hF0);
        check("wake oHaltWake", {7'd0, o_wake}, 8'h01);
        check("wake oIrqReq", {7'd0, o_irq}, 8'h00);

        // ---- Reset during DISPATCH (vector 0x50) ----
        step(in_only(0, 5'h00, 0, 0, 0, 0, 0, 1, 8'h04, 0));
        step(in_only(0, 5'h04, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        step(in_only(0, 5'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0));
        step(in_only(0, 5'h00, 1, 0, 0, 0, 0, 0, 8'h00, 0));
        check("rstdisp pre oIrqReq", {7'd0, o_irq}, 8'h01);
        check("rstdisp pre oIrqVector", o_vec, 8'h50);
        step(in_only(1, 5'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        check("rstdisp oIrqReq", {7'd0, o_irq}, 8'h00);
        check("rstdisp oIf", o_if, 8'hE0);
        check("rstdisp oIe", o_ie, 8'h00);
        check("rstdisp oIme", {7'd0, o_ime}, 8'h00);
        check("rstdisp oIrqVector", o_vec, 8'h00);
        // Stale ack after reset must not disturb anything.
        step(in_only(0, 5'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1));
        check("rstdisp ack oIf", o_if, 8'hE0);
        check("rstdisp ack oIrqReq", {7'd0, o_irq}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 iClock  input  1  system clock; all state changes on its rising edge.
REQ-002 iReset  input  1  reset, synchronous, active-high.
REQ-003 iInt0x40, iInt0x48, iInt0x50, iInt0x58, iInt0x60  input  1 each  one-cycle request pulses: VBlank, LCD STAT, timer (timer block oInterrupt0x50), serial, joypad.
REQ-004 iEof  input  1  end-of-instruction strobe from CPU; the only point where dispatch is decided.
REQ-005 iEi, iDi, iReti  input  1 each  one-cycle decode pulses for EI, DI, RETI.
REQ-006 iMcuWeIf, iMcuWeIe  input  1 each  CPU write strobes for 0xFF0F (IF) and 0xFFFF (IE).
REQ-007 iMcuWriteData  input  8  CPU write data.
REQ-008 iDispatchAck  input  1  CPU has pushed PC and is jumping to oIrqVector.
REQ-009 oIf  output  8  IF readback: {3'b111, flags[4:0]}.
REQ-010 oIe  output  8  IE register, all 8 bits stored.
REQ-011 oIme  output  1  master enable.
REQ-012 oIrqReq  output  1  dispatch request to CPU, held until iDispatchAck.
REQ-013 oIrqVector  output  8  0x40/0x48/0x50/0x58/0x60 of latched source.
REQ-014 oHaltWake  output  1  combinational |(flags & IE[4:0]), independent of IME.

Function
REQ-015 Flag bit k SHALL set on the cycle after its request pulse (latency 1).
REQ-016 IF write: flags <= iMcuWriteData[4:0] | new requests same cycle; set wins over write.
REQ-017 IE write: IE <= iMcuWriteData, visible next cycle.
REQ-018 FSM states IDLE, DISPATCH; encodings shared constants.
REQ-019 IDLE->DISPATCH when iEof=1, IME=1, iDi=0 and (flags & IE[4:0]) != 0; else stay IDLE.
REQ-020 On that transition: latch lowest set bit of (flags & IE[4:0]) as index (bit0 highest priority), IME<=0, oIrqReq<=1, oIrqVector<=0x40+8*index.
REQ-021 In DISPATCH, requests keep setting flags; IE/IF writes honoured; latched index and vector SHALL NOT change.
REQ-022 DISPATCH->IDLE on iDispatchAck: clear flag[index] (a new request for the same bit in that cycle wins), oIrqReq<=0, oIrqVector holds.
REQ-023 iDispatchAck while IDLE SHALL be ignored.
REQ-024 iDi: IME<=0 next cycle and cancel pending EI; iDi with iEof same cycle blocks dispatch.
REQ-025 iEi: set eiPending; IME<=1 on the second iEof after iEi (EI own boundary, then following instruction); dispatch may occur only at a later iEof.
REQ-026 iReti: IME<=1 next cycle, clears eiPending.
REQ-027 Simultaneous iEi and iDi: iDi wins.
REQ-028 Flags SHALL persist while IME=0 or IE bit clear; no request lost.

Reset
REQ-029 iReset: state IDLE, flags 0, IE 0x00, IME 0, eiPending 0, oIrqReq 0, oIrqVector 0x00; oIf reads 0xE0.
REQ-030 Reset during DISPATCH SHALL abort without clearing any flag post-reset (all already zeroed).
REQ-031 Request pulses coincident with iReset SHALL be discarded.

Structure
REQ-032 Vector constants (0x40..0x60), FSM state encodings, IF/IE addresses SHALL live in the shared definitions header.
REQ-033 One sub-module interrupt_priority_encoder: 5-bit pending in -> 3-bit index + valid, purely combinational.
REQ-034 Registers use the shared FFD_POSEDGE_SYNCRONOUS_RESET primitive.

Verification
REQ-035 IME=1, IE=0x04, pulse iInt0x50, then iEof -> oIrqReq=1, oIrqVector=0x50, oIme=0; iDispatchAck -> oIf=0xE0, oIrqReq=0.
REQ-036 IE=0x1F, flags 0x12 pending, iEof with IME=1 -> vector 0x48; after ack oIf=0xF0; next iEof with IME=0 -> no dispatch.
REQ-037 iEi pulse, IE=0x01, flag0 set: first iEof no dispatch, oIme=0; second iEof oIme=1 next cycle; third iEof -> vector 0x40.
REQ-038 IF write 0x00 same cycle as iInt0x60 -> oIf=0xF0; IME=0, IE=0x10 -> oHaltWake=1, oIrqReq=0.
REQ-039 In DISPATCH (vector 0x50) assert iReset -> next cycle oIrqReq=0, oIf=0xE0, oIe=0x00, oIme=0.
